counter_presc_ud: RTL and testbench
===================================

// Module: counter_presc_ud
// PURPOSE
//   Parametrised up/down counter with an integrated clock-enable prescaler, sync load/clear and terminal-count pulse.
//   Next generation of the free-running prescaled counter: all logic runs on clk (no derived clock domain).
//   Feeds LED/display banks and sequencing logic that need a slow, controllable count.
// PARAMETERS
//   W        9          counter width in bits
//   DIV      1048576    prescale ratio: one count step per DIV enabled clk cycles (DIV>=1; 2^20 = legacy N=20)
//   MAX_VAL  2**W-1     upper count bound; wrap/saturate point (MAX_VAL <= 2**W-1)
//   PW       $clog2(DIV) (localparam, min 1) prescaler counter width
// PORTS
//   clk       in   1   system clock; all state updates on posedge
//   rstn      in   1   synchronous reset, active low
//   en        in   1   count enable; gates prescaler and counter
//   dir       in   1   1 = count up, 0 = count down
//   clr       in   1   synchronous clear of counter and prescaler
//   load      in   1   synchronous load of load_val
//   load_val  in   W   value to load (clamped to MAX_VAL)
//   data      out  W   current count (registered)
//   tick      out  1   registered; high for the one cycle following each prescaler rollover
//   tc        out  1   registered terminal-count pulse; high one cycle after each wrap (or saturating hit)
// BEHAVIOUR
//   - One clock (clk); reset synchronous, active-low (rstn). All outputs registered.
//   - Reset (rstn=0 at posedge): data=0, tick=0, tc=0, prescaler p=0. Overrides everything, including mid-count.
//   - Priority per edge: rstn > clr > load > count step.
//   - clr=1: data=0, p=0, tick=0, tc=0; independent of en.
//   - load=1 (clr=0): data=min(load_val,MAX_VAL), p=0, tick=0, tc=0; independent of en.
//   - en=0: data and p hold (prescaler phase preserved); tick=0, tc=0.
//   - en=1: if p==DIV-1 then p=0, tick=1 and data steps on the same edge; else p=p+1, tick=0.
//     DIV=1: step every enabled cycle, tick stays 1 while en=1.
//   - Step up: data==MAX_VAL -> data=0, tc=1; else data+1, tc=0.
//   - Step down: data==0 -> data=MAX_VAL, tc=1; else data-1, tc=0.
//   - dir sampled only on the stepping edge; changing dir between steps is legal.
//   - data never exceeds MAX_VAL; arithmetic is W-bit, with no carry beyond W.
//   - Latency: first step DIV enabled cycles after reset/clr/load; tick, tc and new data become visible together.
// CONFIGURATION
//   Macro CTR_SATURATE_EN:
//     defined     -> stepping past a bound holds data (MAX_VAL going up, 0 going down); tc=1 on each such
//                    blocked step; tick is unaffected.
//     not defined -> wrap-around as described above (default).
// STRUCTURE
//   - Package ctr_pkg: DIR_UP/DIR_DOWN constants and the clog2-with-min-1 helper function.
//   - Sub-module tick_gen (params DIV, PW; ports clk, rstn, en, restart, tick): prescaler counter.
//     restart = clr|load. Top level holds counter and bound logic.
// TESTING (W=4, DIV=3, MAX_VAL=15 unless stated)
//   1. Apply rstn=0 for 2 cycles, then hold rstn=0 mid-count later -> data=0, tick=0, tc=0 on the next edge
//      both times.
//   2. rstn=1, en=1, dir=1 for 9 cycles -> tick high on cycles 3,6,9; data 1,2,3 on those edges; tc=0.
//   3. load=1 with load_val=15, then count up -> after 3 cycles data=0 and tc=1 for exactly one cycle.
//   4. clr, then dir=0 and count -> after 3 cycles data=15, tc=1; after 3 more data=14, tc=0.
//   5. clr=1 and load=1 in the same cycle -> data=0.
//      MAX_VAL=12 with load_val=14 -> data=12; next up step -> data=0, tc=1.
//   6. en=0 for 5 cycles at p=1 -> data, p held, tick=0; en=1 -> step after 1 more cycle.
//      With CTR_SATURATE_EN: at data=15, up -> data stays 15, tc=1 on each step.

Source files
------------

// File: rtl/ctr_pkg.sv
// ============================================================================
//  Package : ctr_pkg
//  Purpose : Shared constants and helpers for the prescaled up/down counter.
//            DIR_UP / DIR_DOWN encode the 'dir' input. clog2_min1 sizes
//            the prescaler so that DIV=1 still gets a 1-bit register.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ctr_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2 with a floor of 1, so no register ever ends up zero width.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : ctr_pkg

`default_nettype wire

// File: rtl/counter_presc_ud_tick_gen.sv
// ============================================================================
//  Module  : tick_gen
//  Purpose : Clock-enable prescaler. Counts enabled clk cycles and raises a
//            one-cycle strobe on the cycle whose edge rolls the prescaler
//            over (phase DIV-1). The strobe is combinational so the parent
//            can step its counter on that same edge and register the
//            visible tick alongside the new count.
//  Ports   : clk     in  system clock
//            rstn    in  synchronous reset, active low
//            en      in  advance the prescaler
//            restart in  return the prescaler to phase 0 (clear/load)
//            tick    out rollover strobe, valid for the current edge
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen
  import ctr_pkg::*;
#(
  parameter int DIV = 1048576,
  parameter int PW  = clog2_min1(DIV)
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] p;
  logic          at_last;

  assign at_last = (p == LAST);
  // Restart wins over a rollover landing on the same edge.
  assign tick    = en & at_last & ~restart;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      p <= '0;
    end else if (restart) begin
      p <= '0;
    end else if (en) begin
      if (at_last) begin
        p <= '0;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

endmodule : tick_gen

`default_nettype wire

// File: rtl/counter_presc_ud.sv
// ============================================================================
//  Module  : counter_presc_ud
//  Purpose : W-bit up/down counter bounded by MAX_VAL, stepped once every
//            DIV enabled clk cycles, with synchronous clear and load and a
//            registered terminal-count pulse.
//  Ports   : clk       in  system clock
//            rstn      in  synchronous reset, active low
//            en        in  count enable (prescaler and counter)
//            dir       in  1 = up, 0 = down (sampled on stepping edges)
//            clr       in  clear counter and prescaler
//            load      in  load load_val (clamped to MAX_VAL)
//            load_val  in  value to load
//            data      out current count
//            tick      out one cycle high after each prescaler rollover
//            tc        out one cycle high after each wrap/saturating hit
//  Config  : CTR_SATURATE_EN defined -> hold at the bound instead of wrap.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_presc_ud
  import ctr_pkg::*;
#(
  parameter int W       = 9,
  parameter int DIV     = 1048576,
  parameter int MAX_VAL = 2**W - 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] data,
  output logic         tick,
  output logic         tc
);

  localparam int          PW    = clog2_min1(DIV);
  localparam logic [W-1:0] TOP  = W'(MAX_VAL);

  logic         step;
  logic [W-1:0] load_clamped;

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .restart (clr | load),
    .tick    (step)
  );

  assign load_clamped = (load_val > TOP) ? TOP : load_val;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data <= '0;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else if (clr) begin
      data <= '0;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else if (load) begin
      data <= load_clamped;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else begin
      // step is already gated by en inside the prescaler.
      tick <= step;
      tc   <= 1'b0;
      if (step) begin
        if (dir == DIR_UP) begin
          if (data == TOP) begin
`ifdef CTR_SATURATE_EN
            data <= TOP;
`else
            data <= '0;
`endif
            tc   <= 1'b1;
          end else begin
            data <= data + 1'b1;
          end
        end else begin
          if (data == '0) begin
`ifdef CTR_SATURATE_EN
            data <= '0;
`else
            data <= TOP;
`endif
            tc   <= 1'b1;
          end else begin
            data <= data - 1'b1;
          end
        end
      end
    end
  end

endmodule : counter_presc_ud

`default_nettype wire

// File: tb/tb_counter_presc_ud.sv
// ============================================================================
//  Module  : tb_counter_presc_ud
//  Purpose : Directed, table-driven bench for counter_presc_ud (W=4, DIV=3,
//            MAX_VAL=15) plus a second instance with MAX_VAL=12 for the
//            load clamp and reduced bound.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_presc_ud;

  typedef struct {
    logic       rstn;
    logic       en;
    logic       dir;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_data;
    logic       exp_tick;
    logic       exp_tc;
  } vec_t;

`ifdef CTR_SATURATE_EN
  localparam logic [3:0] U1 = 4'd15, U2 = 4'd15, D1 = 4'd0, D2 = 4'd0, S12 = 4'd12;
  localparam logic       UTC2 = 1'b1, DTC2 = 1'b1;
`else
  localparam logic [3:0] U1 = 4'd0, U2 = 4'd1, D1 = 4'd15, D2 = 4'd14, S12 = 4'd0;
  localparam logic       UTC2 = 1'b0, DTC2 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, en, dir, clr, load;
  logic [3:0] load_val;
  logic [3:0] data, data12;
  logic       tick, tc, tick12, tc12;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  counter_presc_ud #(.W(4), .DIV(3), .MAX_VAL(15)) dut (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .data(data), .tick(tick), .tc(tc)
  );

  counter_presc_ud #(.W(4), .DIV(3), .MAX_VAL(12)) dut12 (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .data(data12), .tick(tick12), .tc(tc12)
  );

  task automatic add(input logic r, input logic e, input logic d, input logic c,
                     input logic l, input logic [3:0] lv,
                     input logic [3:0] xd, input logic xt, input logic xc);
    vec_t v;
    v.rstn = r; v.en = e; v.dir = d; v.clr = c; v.load = l; v.load_val = lv;
    v.exp_data = xd; v.exp_tick = xt; v.exp_tc = xc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1ns later.
  task automatic drive(input logic r, input logic e, input logic d, input logic c,
                       input logic l, input logic [3:0] lv);
    @(negedge clk);
    rstn = r; en = e; dir = d; clr = c; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;

    // Reset for two cycles
    add(0,0,1,0,0,0,  0,0,0);
    add(0,1,1,0,0,0,  0,0,0);
    // Count up 9 enabled cycles: tick on 3,6,9
    add(1,1,1,0,0,0,  0,0,0);
    add(1,1,1,0,0,0,  0,0,0);
    add(1,1,1,0,0,0,  1,1,0);
    add(1,1,1,0,0,0,  1,0,0);
    add(1,1,1,0,0,0,  1,0,0);
    add(1,1,1,0,0,0,  2,1,0);
    add(1,1,1,0,0,0,  2,0,0);
    add(1,1,1,0,0,0,  2,0,0);
    add(1,1,1,0,0,0,  3,1,0);
    // Advance to p=1, pause 5 cycles, resume: step on the 2nd enabled edge
    add(1,1,1,0,0,0,  3,0,0);
    for (int i = 0; i < 5; i++) add(1,0,1,0,0,0,  3,0,0);
    add(1,1,1,0,0,0,  3,0,0);
    add(1,1,1,0,0,0,  4,1,0);
    // Reset mid-count, then prescaler restarts from phase 0
    add(1,1,1,0,0,0,  4,0,0);
    add(0,1,1,0,0,0,  0,0,0);
    add(1,1,1,0,0,0,  0,0,0);
    add(1,1,1,0,0,0,  0,0,0);
    add(1,1,1,0,0,0,  1,1,0);
    // Load 15 and count up across the top bound, then one more step
    add(1,1,1,0,1,15, 15,0,0);
    add(1,1,1,0,0,0,  15,0,0);
    add(1,1,1,0,0,0,  15,0,0);
    add(1,1,1,0,0,0,  U1,1,1);
    add(1,1,1,0,0,0,  U1,0,0);
    add(1,1,1,0,0,0,  U1,0,0);
    add(1,1,1,0,0,0,  U2,1,UTC2);
    // Clear, then count down across zero and one more step
    add(1,1,0,1,0,0,  0,0,0);
    add(1,1,0,0,0,0,  0,0,0);
    add(1,1,0,0,0,0,  0,0,0);
    add(1,1,0,0,0,0,  D1,1,1);
    add(1,1,0,0,0,0,  D1,0,0);
    add(1,1,0,0,0,0,  D1,0,0);
    add(1,1,0,0,0,0,  D2,1,DTC2);
    // clr beats load; then load with en=0; up then down (dir change)
    add(1,1,1,1,1,9,  0,0,0);
    add(1,0,1,0,1,7,  7,0,0);
    add(1,1,1,0,0,0,  7,0,0);
    add(1,1,1,0,0,0,  7,0,0);
    add(1,1,1,0,0,0,  8,1,0);
    add(1,1,0,0,0,0,  8,0,0);
    add(1,1,0,0,0,0,  8,0,0);
    add(1,1,0,0,0,0,  7,1,0);

    foreach (vq[i]) begin
      drive(vq[i].rstn, vq[i].en, vq[i].dir, vq[i].clr, vq[i].load, vq[i].load_val);
      chk($sformatf("v%0d data", i), 32'(data), 32'(vq[i].exp_data));
      chk($sformatf("v%0d tick", i), 32'(tick), 32'(vq[i].exp_tick));
      chk($sformatf("v%0d tc",   i), 32'(tc),   32'(vq[i].exp_tc));
    end

    // MAX_VAL=12 instance: load 14 clamps to 12, next up step crosses the bound
    drive(1,0,1,0,1,14);
    chk("m12 load clamp", 32'(data12), 32'd12);
    chk("m15 load 14",    32'(data),   32'd14);
    drive(1,1,1,0,0,0);
    drive(1,1,1,0,0,0);
    chk("m12 pre-step", 32'(data12), 32'd12);
    drive(1,1,1,0,0,0);
    chk("m12 bound data", 32'(data12), 32'(S12));
    chk("m12 bound tc",   32'(tc12),   32'd1);
    chk("m12 bound tick", 32'(tick12), 32'd1);
    chk("m15 step data",  32'(data),   32'd15);
    chk("m15 step tc",    32'(tc),     32'd0);
    drive(1,1,1,0,0,0);
    chk("m12 tc drop", 32'(tc12), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_presc_ud

`default_nettype wire
